alu_sched: RTL



---
 rtl/alu_sched_pkg.sv | 14 +
 rtl/alu_sched_if.sv | 32 +++
 rtl/alu_sched_rr_arbiter.sv | 67 ++++++
 rtl/alu_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

  localparam int unsigned ALU_W             = 8;
  localparam int unsigned ALU_SCHED_MAX_REQ = 4;
  localparam int unsigned ALU_S_W           = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_sched_state_t;

endpackage : alu_sched_pkg

// File: rtl/alu_sched_if.sv
// Request/response bundle between the requesters, the consumer and alu_sched.
interface alu_sched_if
  import alu_sched_pkg::*;
#(
  parameter int unsigned W    = ALU_W,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*W-1:0]       req_a;
  logic [NREQ*W-1:0]       req_b;
  logic [NREQ-1:0]         req_ctrl;
  logic [NREQ*ALU_S_W-1:0] req_s;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [W-1:0]            rsp_y;
  logic [IDW-1:0]          rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, req_s, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, req_s, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id
  );

endinterface : alu_sched_if

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational grant selection: round-robin from last_i+1 by default,
// lowest-index-wins when ALU_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_c_o,
  output logic [IDW-1:0]  idx_c_o
);

  logic found_c;

  if ((NREQ < 2) || (NREQ > ALU_SCHED_MAX_REQ)) begin : g_bad_nreq
    $error("rr_arbiter: NREQ out of range");
  end

`ifdef ALU_SCHED_FIXED_PRIO_EN

  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    found_c = 1'b0;
    idx_c_o = '0;
    if (en_i) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found_c && req_i[i]) begin
          found_c = 1'b1;
          idx_c_o = IDW'(i);
        end
      end
    end
  end

`else

  int unsigned     cand_c;
  logic [NREQ-1:0] shifted_c;

  // Walk candidates last+1, last+2, ... wrapping, first requester found wins.
  always_comb begin
    found_c   = 1'b0;
    idx_c_o   = '0;
    cand_c    = 0;
    shifted_c = '0;
    if (en_i) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand_c    = (32'(last_i) + k) % NREQ;
        shifted_c = req_i >> cand_c;
        if (!found_c && shifted_c[0]) begin
          found_c = 1'b1;
          idx_c_o = IDW'(cand_c);
        end
      end
    end
  end

`endif

  assign grant_c_o = found_c ? (NREQ'(1) << idx_c_o) : '0;

endmodule : rr_arbiter

// File: rtl/alu_sched.sv
// Time-shares one combinational ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// ALU_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned W    = ALU_W,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_sched_if.slave         bus,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic               alu_ctrl,
  output logic [ALU_S_W-1:0] alu_s,
  input  logic [W-1:0]       alu_y,
  output logic               busy
);

  alu_sched_state_t state_q, state_d;

  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               ctrl_q, ctrl_d;
  logic [ALU_S_W-1:0] s_q, s_d;
  logic [W-1:0]       y_q, y_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [IDW-1:0]     last_c;
  logic [NREQ-1:0]    grant_c;
  logic [IDW-1:0]     grant_idx_c;
  logic               arb_en_c;
  logic [NREQ-1:0]    req_ready_c;

  logic [W-1:0]       mux_a_c;
  logic [W-1:0]       mux_b_c;
  logic               mux_ctrl_c;
  logic [ALU_S_W-1:0] mux_s_c;

  if ((IDW < 1) || ((1 << IDW) < NREQ)) begin : g_bad_idw
    $error("alu_sched: IDW too narrow for NREQ");
  end

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign last_c = '0;
`else
  logic [IDW-1:0] last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign last_d = (state_q == IDLE && grant_c != '0) ? grant_idx_c : last_q;
  assign last_c = last_q;
`endif

  assign arb_en_c = (state_q == IDLE);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (bus.req_valid),
    .last_i    (last_c),
    .en_i      (arb_en_c),
    .grant_c_o (grant_c),
    .idx_c_o   (grant_idx_c)
  );

  // One-hot mux of the winning requester's payload.
  always_comb begin
    mux_a_c    = '0;
    mux_b_c    = '0;
    mux_ctrl_c = 1'b0;
    mux_s_c    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        mux_a_c    = bus.req_a[i*W +: W];
        mux_b_c    = bus.req_b[i*W +: W];
        mux_ctrl_c = bus.req_ctrl[i];
        mux_s_c    = bus.req_s[i*ALU_S_W +: ALU_S_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      s_q     <= '0;
      y_q     <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      s_q     <= s_d;
      y_q     <= y_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Operand registers keep their last value between operations.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    s_d         = s_q;
    y_d         = y_q;
    id_d        = id_q;
    req_ready_c = '0;

    case (state_q)
      IDLE: begin
        if (grant_c != '0) begin
          req_ready_c = grant_c;
          a_d         = mux_a_c;
          b_d         = mux_b_c;
          ctrl_d      = mux_ctrl_c;
          s_d         = mux_s_c;
          id_d        = grant_idx_c;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        y_d     = alu_y;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = id_q;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;
  assign alu_s    = s_q;
  assign busy     = busy_q;

endmodule : alu_sched
